// File: rtl/modn_counter_pkg.sv
// Shared constants and helpers for the cascaded modulo-N counter.
// Digit width and load clamping live here so every stage agrees.
package modn_counter_pkg;

    localparam int MOD_DEF = 10;
    localparam int DIG_DEF = 4;

    function automatic int digit_width(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [31:0] digit_max(input int m);
        return 32'(m - 1);
    endfunction

    function automatic logic [31:0] clamp_digit(
        input logic [31:0] v,
        input int          m
    );
        return (v >= 32'(m)) ? digit_max(m) : v;
    endfunction

endpackage

// File: rtl/modn_cascade_counter_if.sv
// Control/status bundle of the cascaded counter.
// The master drives commands, the slave returns count and flags.
interface modn_cascade_counter_if
    import modn_counter_pkg::*;
#(
    parameter int MODULUS = MOD_DEF,
    parameter int DIGITS  = DIG_DEF
);
    localparam int DW = digit_width(MODULUS);

    logic                 en;
    logic                 up;
    logic                 clear;
    logic                 load;
    logic [DIGITS*DW-1:0] load_val;
    logic [DIGITS*DW-1:0] q;
    logic                 tc;
    logic                 wrap;

    modport master (
        output en, up, clear, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up, clear, load, load_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/modn_digit.sv
// One modulo-MODULUS digit: clear > load > carry-in step.
// Reports at_max/at_zero so the top can build the carry chain.
module modn_digit
    import modn_counter_pkg::*;
#(
    parameter  int MODULUS = MOD_DEF,
    localparam int DW      = digit_width(MODULUS)
)(
    input  logic          clk,
    input  logic          internal_reset,
    input  logic          cin_i,
    input  logic          up_i,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_d_i,
    output logic [DW-1:0] val_o,
    output logic          at_max_o,
    output logic          at_zero_o
);
    localparam logic [DW-1:0] MAX = DW'(digit_max(MODULUS));

    logic [DW-1:0] val_q, val_d;

    assign at_max_o  = (val_q == MAX);
    assign at_zero_o = (val_q == '0);
    assign val_o     = val_q;

    always_comb begin
        val_d = val_q;
        if (clear_i) begin
            val_d = '0;
        end else if (load_i) begin
            val_d = DW'(clamp_digit(32'(load_d_i), MODULUS));
        end else if (cin_i) begin
            if (up_i) begin
                val_d = at_max_o ? '0 : val_q + 1'b1;
            end else begin
                val_d = at_zero_o ? MAX : val_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge internal_reset) begin
        if (internal_reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end
endmodule

// File: rtl/modn_cascade_counter.sv
// Synchronous cascaded modulo-N counter, single clock domain.
// Carry is a prefix-AND of per-digit at_max/at_zero picked by up.
module modn_cascade_counter
    import modn_counter_pkg::*;
#(
    parameter int MODULUS = MOD_DEF,
    parameter int DIGITS  = DIG_DEF
)(
    input logic                   clk,
    input logic                   internal_reset,
    modn_cascade_counter_if.slave bus
);
    localparam int DW = digit_width(MODULUS);

    logic [DIGITS-1:0]    at_max;
    logic [DIGITS-1:0]    at_zero;
    logic [DIGITS-1:0]    hit;
    logic [DIGITS:0]      run;
    logic [DIGITS*DW-1:0] q;
    logic                 wrap_q, wrap_d;

    assign run[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign hit[i]   = bus.up ? at_max[i] : at_zero[i];
        assign run[i+1] = run[i] & hit[i];

        modn_digit #(.MODULUS(MODULUS)) u_digit (
            .clk            (clk),
            .internal_reset (internal_reset),
            .cin_i          (bus.en & run[i]),
            .up_i           (bus.up),
            .clear_i        (bus.clear),
            .load_i         (bus.load),
            .load_d_i       (bus.load_val[i*DW +: DW]),
            .val_o          (q[i*DW +: DW]),
            .at_max_o       (at_max[i]),
            .at_zero_o      (at_zero[i])
        );
    end

    // Whole chain wraps when every digit sits at its turning point.
    assign bus.tc = run[DIGITS];
    assign wrap_d = bus.en & bus.tc & ~bus.clear & ~bus.load;

    always_ff @(posedge clk or posedge internal_reset) begin
        if (internal_reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_modn_cascade_counter.sv
// Directed bench for modn_cascade_counter at MODULUS=10, DIGITS=3.
// Digits are 4 bits wide, so expected counts read as BCD hex.
module tb_modn_cascade_counter;

    logic clk;
    logic internal_reset;
    int   n_chk;
    int   n_pass;

    modn_cascade_counter_if #(.MODULUS(10), .DIGITS(3)) bus ();

    modn_cascade_counter #(.MODULUS(10), .DIGITS(3)) dut (
        .clk            (clk),
        .internal_reset (internal_reset),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [11:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        n_chk          = 0;
        n_pass         = 0;
        internal_reset = 1'b1;
        bus.en         = 1'b0;
        bus.up         = 1'b1;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.load_val   = '0;

        #3;
        chk("rst_q", 32'(bus.q), 32'h000);
        chk("rst_wrap", 32'(bus.wrap), 32'h0);
        chk("rst_tc_up", 32'(bus.tc), 32'h0);
        bus.up = 1'b0;
        #1;
        chk("rst_tc_dn", 32'(bus.tc), 32'h1);
        bus.up = 1'b1;
        #8;
        internal_reset = 1'b0;

        // Full up count to the top and across the wrap
        bus.en = 1'b1;
        repeat (999) step();
        chk("up999_q", 32'(bus.q), 32'h999);
        chk("up999_tc", 32'(bus.tc), 32'h1);
        chk("up999_wrap", 32'(bus.wrap), 32'h0);
        step();
        chk("upwrap_q", 32'(bus.q), 32'h000);
        chk("upwrap_wrap", 32'(bus.wrap), 32'h1);
        chk("upwrap_tc", 32'(bus.tc), 32'h0);
        step();
        chk("up001_q", 32'(bus.q), 32'h001);
        chk("up001_wrap", 32'(bus.wrap), 32'h0);

        // Down count with borrow and bottom wrap
        bus.en = 1'b0;
        do_load(12'h200);
        chk("ld200_q", 32'(bus.q), 32'h200);
        chk("ld200_wrap", 32'(bus.wrap), 32'h0);
        bus.en = 1'b1;
        bus.up = 1'b0;
        step();
        chk("dn199_q", 32'(bus.q), 32'h199);
        chk("dn199_tc", 32'(bus.tc), 32'h0);
        repeat (199) step();
        chk("dn000_q", 32'(bus.q), 32'h000);
        chk("dn000_tc", 32'(bus.tc), 32'h1);
        step();
        chk("dnwrap_q", 32'(bus.q), 32'h999);
        chk("dnwrap_wrap", 32'(bus.wrap), 32'h1);
        chk("dnwrap_tc", 32'(bus.tc), 32'h0);

        // Load clamping of out-of-range digits
        bus.en = 1'b0;
        do_load(12'h5A3);
        chk("clampmid_q", 32'(bus.q), 32'h593);
        chk("clampmid_wrap", 32'(bus.wrap), 32'h0);
        do_load(12'hF0C);
        chk("clampall_q", 32'(bus.q), 32'h909);

        // Priority: clear beats load beats en
        bus.clear    = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 12'h777;
        bus.en       = 1'b1;
        step();
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        chk("prio_clr_q", 32'(bus.q), 32'h000);
        chk("prio_clr_wrap", 32'(bus.wrap), 32'h0);

        bus.en = 1'b0;
        bus.up = 1'b1;
        do_load(12'h999);
        chk("prio_tc", 32'(bus.tc), 32'h1);
        bus.en = 1'b1;
        do_load(12'h123);
        chk("prio_ld_q", 32'(bus.q), 32'h123);
        chk("prio_ld_wrap", 32'(bus.wrap), 32'h0);

        // Hold with en low; direction only affects tc
        bus.en = 1'b0;
        do_load(12'h457);
        for (int i = 0; i < 20; i++) begin
            bus.up = i[0];
            step();
            chk("hold_q", 32'(bus.q), 32'h457);
            chk("hold_wrap", 32'(bus.wrap), 32'h0);
        end
        bus.up = 1'b0;
        do_load(12'h000);
        chk("dir_tc_dn", 32'(bus.tc), 32'h1);
        bus.up = 1'b1;
        #1;
        chk("dir_tc_up", 32'(bus.tc), 32'h0);
        chk("dir_q", 32'(bus.q), 32'h000);

        // Asynchronous reset mid-cycle
        do_load(12'h318);
        chk("pre_rst_q", 32'(bus.q), 32'h318);
        #2;
        internal_reset = 1'b1;
        #1;
        chk("async_q", 32'(bus.q), 32'h000);
        chk("async_wrap", 32'(bus.wrap), 32'h0);
        #1;
        internal_reset = 1'b0;
        bus.en = 1'b1;
        bus.up = 1'b1;
        step();
        chk("post_rst_q", 32'(bus.q), 32'h001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
